// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: streams weights from a synchronous memory through
// one shared multiply-accumulate and emits a ReLU-saturated byte per neuron.
module fc_layer_sequencer #(
  parameter int N_IN  = 10,
  parameter int N_OUT = 10,
  parameter int ACC_W = 20
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [8*N_IN-1:0]                in_vec,
  input  logic [8*N_OUT-1:0]               bias_vec,
  output logic                             wt_en,
  output logic [$clog2(N_IN*N_OUT)-1:0]    wt_addr,
  input  logic [7:0]                       wt_rdata,
  output logic                             busy,
  output logic                             out_valid,
  output logic [$clog2(N_OUT)-1:0]         out_idx,
  output logic [7:0]                       out_data,
  output logic [8*N_OUT-1:0]               out_vec,
  output logic                             done
);

  localparam int JW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int IW = $clog2(N_OUT);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

  state_t                   state;
  logic [IW-1:0]            i;
  logic [JW-1:0]            j;
  logic signed [ACC_W-1:0]  acc;
  logic [7:0]               in_r   [N_IN];
  logic [7:0]               bias_r [N_OUT];

  logic signed [16:0]       prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [7:0]               result;

  function automatic logic [7:0] relu_sat(input logic signed [ACC_W-1:0] a);
    if (a[ACC_W-1])
      return 8'd0;
    else if (|a[ACC_W-2:8])
      return 8'd255;
    else
      return a[7:0];
  endfunction

  // Unsigned activation times signed weight, both widened to 17 bits so the product is exact.
  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    prod    = $signed({9'd0, in_r[j]}) * $signed({{9{wt_rdata[7]}}, wt_rdata});
    acc_sum = acc + {{(ACC_W-17){prod[16]}}, prod};
    result  = relu_sat(acc_sum);
  end

  assign busy = (state != IDLE);

  // Outputs are registered: each is set on the edge that enters the state in which it is seen.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the in_r/bias_r operand captures have no reset; they are always loaded before use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      acc       <= '0;
      wt_en     <= 1'b0;
      wt_addr   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_vec   <= '0;
      done      <= 1'b0;
    end else begin
      wt_en     <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              for (int k = 0; k < N_IN; k++)  in_r[k]   <= in_vec[8*k +: 8];
              for (int k = 0; k < N_OUT; k++) bias_r[k] <= bias_vec[8*k +: 8];
              i       <= '0;
              wt_en   <= 1'b1;
              wt_addr <= '0;
              state   <= LOAD;
            end
          end
          LOAD: begin
            acc <= {{(ACC_W-8){bias_r[i][7]}}, bias_r[i]};
            j   <= '0;
            if (N_IN > 1) begin
              wt_en   <= 1'b1;
              wt_addr <= wt_addr + 1'b1;
            end
            state <= MAC;
          end
          MAC: begin
            acc <= acc_sum;
            if (j == JW'(N_IN-1)) begin
              out_valid             <= 1'b1;
              out_idx               <= i;
              out_data              <= result;
              out_vec[8*i +: 8]     <= result;
              state                 <= WRITE;
            end else begin
              j <= j + 1'b1;
              if (j < JW'(N_IN-2)) begin
                wt_en   <= 1'b1;
                wt_addr <= wt_addr + 1'b1;
              end
            end
          end
          WRITE: begin
            if (i == IW'(N_OUT-1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // Addresses are contiguous, so the next neuron's row starts one past the last read.
              i       <= i + 1'b1;
              wt_en   <= 1'b1;
              wt_addr <= wt_addr + 1'b1;
              state   <= LOAD;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/fc_layer_sequencer.md
FC_LAYER_SEQUENCER -- requirements
Module: fc_layer_sequencer

Interface
REQ-001 Parameter: N_IN, default 10, input-vector length (neurons' fan-in).
REQ-002 Parameter: N_OUT, default 10, neuron count.
REQ-003 Parameter: ACC_W, default 20, signed accumulator width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a layer evaluation; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of an evaluation in progress.
REQ-008 in_vec  input  8*N_IN  unsigned activations; element j at bits [8j+7:8j].
REQ-009 bias_vec  input  8*N_OUT  signed biases; element i at bits [8i+7:8i].
REQ-010 wt_en  output  1  weight-memory read enable.
REQ-011 wt_addr  output  clog2(N_IN*N_OUT)  weight address = i*N_IN + j.
REQ-012 wt_rdata  input  8  signed weight; valid the cycle after a wt_en cycle (1-cycle synchronous read).
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 out_valid  output  1  one-cycle pulse per finished neuron.
REQ-015 out_idx  output  clog2(N_OUT)  neuron index qualified by out_valid.
REQ-016 out_data  output  8  activated result qualified by out_valid.
REQ-017 out_vec  output  8*N_OUT  registered copy of all results; element i updated when neuron i is written.
REQ-018 done  output  1  one-cycle pulse after the last neuron of a non-aborted evaluation.

Function
REQ-019 FSM states: IDLE, LOAD, MAC, WRITE, DONE; one shared multiply-accumulate.
REQ-020 IDLE: start=1 and abort=0 -> capture in_vec and bias_vec into internal registers, i=0, go to LOAD; otherwise stay.
REQ-021 LOAD (1 cycle): acc <= sign-extended bias[i]; wt_en=1, wt_addr=i*N_IN; j=0; go to MAC.
REQ-022 MAC (N_IN cycles, j=0..N_IN-1): acc <= acc + in[j]*wt_rdata; wt_en=1 with wt_addr=i*N_IN+j+1 while j<N_IN-1, else wt_en=0; after j=N_IN-1 go to WRITE.
REQ-023 Product: unsigned 8-bit x signed 8-bit -> signed 17-bit, sign-extended to ACC_W; no overflow possible at defaults.
REQ-024 WRITE (1 cycle): out_valid=1, out_idx=i, out_data=relu_sat(acc); out_vec element i <= same value; if i=N_OUT-1 go to DONE, else i<=i+1, go to LOAD.
REQ-025 relu_sat: acc<0 -> 0; acc>255 -> 255; else acc[7:0].
REQ-026 DONE (1 cycle): done=1; go to IDLE.
REQ-027 Latency: neuron k WRITE in cycle (N_IN+2)*(k+1) after the start-accept edge; done in cycle N_OUT*(N_IN+2)+1 (121 at defaults).
REQ-028 start while busy is ignored; captured operands remain fixed for the whole evaluation regardless of in_vec/bias_vec changes.
REQ-029 abort=1 in any non-IDLE state -> IDLE next edge; no out_valid or done that cycle or after; out_vec keeps elements already written.
REQ-030 abort and start together in IDLE -> start ignored.
REQ-031 wt_en, out_valid, done are 0 in every cycle not listed above; wt_addr holds its last value when wt_en=0.

Reset
REQ-032 reset=1 -> state IDLE, i=j=0, acc=0, out_vec=0, out_data=0, out_idx=0, wt_addr=0, wt_en=busy=out_valid=done=0, immediately and independent of clk.
REQ-033 Reset mid-evaluation discards it; no done follows; next start begins a fresh evaluation.

Verification
REQ-034 All in=1, all weights=1, all biases=0, start -> out_valid for idx 0..9 each with data 10, done in cycle 121.
REQ-035 in[0]=255, weight(0,0)=127, others 0, bias[0]=0 -> out_data 255 for idx 0 (saturation); bias[1]=-5, others 0 -> idx 1 data 0 (ReLU).
REQ-036 in all 255, weights all -128, biases 127 -> every output 0; acc reaches -326273 without wrap.
REQ-037 Pulse start at cycle 50 of a run and change in_vec -> ignored, results match original operands, single done.
REQ-038 abort during neuron 4 MAC -> busy low next cycle, no further out_valid, no done; out_vec[0..3] retained; new start completes normally.
REQ-039 Assert reset in neuron 7 -> all outputs 0 asynchronously; wt_addr sequence after next start begins at 0 and matches i*10+j ordering.
